// File: rtl/shift_pkg.sv
// Shared types and constants for the shift issue stage and its mask generator.
package shift_pkg;

  localparam int N_W = 16;
  localparam int C_W = 4;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SHR = 2'b11
  } op_e;

  typedef struct packed {
    logic [N_W-1:0] data;
    logic [C_W-1:0] cnt;
    op_e            op;
    logic           arith;
  } a_payload_t;

endpackage

// File: rtl/shift_mask_gen.sv
// Keep mask and fill value that turn a left-rotate result into SLL/SRL/SRA.
// Bits where keep is 0 are replaced by the matching fill bit.
module shift_mask_gen
  import shift_pkg::*;
(
  input  op_e            op,
  input  logic           arith,
  input  logic [C_W-1:0] cnt,
  input  logic           sign,
  output logic [N_W-1:0] keep,
  output logic [N_W-1:0] fill
);

  localparam logic [N_W-1:0] ONES = '1;

  // cnt = 0 yields ONES in both shift cases, so no special-casing is needed
  always_comb begin
    keep = ONES;
    fill = '0;
    case (op)
      OP_SLL: keep = ONES << cnt;
      OP_SHR: begin
        keep = ONES >> cnt;
        if (arith) fill = {N_W{sign}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Two-stage valid/ready front end for an external 16-bit left rotator.
// Optional build macro SHIFT_ISSUE_STATS_EN adds stat_ops/stat_stalls counters and stat_clr.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int N = N_W,
  parameter int C = C_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [C-1:0] in_cnt,
  input  logic [1:0]   in_op,
  input  logic         in_arith,
  output logic [N-1:0] rot_in,
  output logic [C-1:0] rot_cnt,
  input  logic [N-1:0] rot_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  input  logic         stat_clr,
  output logic [15:0]  stat_ops,
  output logic [15:0]  stat_stalls
`endif
);

  a_payload_t     a_q;
  logic           a_valid;
  logic           b_ready;
  logic           in_fire;
  logic [N_W-1:0] keep;
  logic [N_W-1:0] fill;
  logic [N_W-1:0] masked;

  assign b_ready  = !out_valid || out_ready;
  assign in_ready = !a_valid || b_ready;
  assign in_fire  = in_valid && in_ready;

  assign rot_in = a_q.data;
  // Right-going ops rotate left by (16 - k) mod 16, i.e. the 4-bit negation of k
  assign rot_cnt = (a_q.op inside {OP_ROL, OP_SLL}) ? a_q.cnt : -a_q.cnt;

  shift_mask_gen u_mask (
    .op    (a_q.op),
    .arith (a_q.arith),
    .cnt   (a_q.cnt),
    .sign  (a_q.data[N_W-1]),
    .keep  (keep),
    .fill  (fill)
  );

  assign masked = (rot_out & keep) | (fill & ~keep);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_q     <= '0;
    end else if (in_fire) begin
      a_valid <= 1'b1;
      a_q     <= '{data: in_data, cnt: in_cnt, op: op_e'(in_op), arith: in_arith};
    end else if (b_ready) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (b_ready) begin
      out_valid <= a_valid;
      if (a_valid) out_data <= masked;
    end
  end

`ifdef SHIFT_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops    <= '0;
      stat_stalls <= '0;
    end else if (stat_clr) begin
      stat_ops    <= '0;
      stat_stalls <= '0;
    end else begin
      if (out_valid && out_ready && stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (out_valid && !out_ready && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: directed table, backpressure, random stream, mid-op reset.
module tb_shift_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        in_arith;
  logic [15:0] rot_in;
  logic [3:0]  rot_cnt;
  logic [15:0] rot_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef SHIFT_ISSUE_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_ops;
  logic [15:0] stat_stalls;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  shift_issue_stage #(.N(16), .C(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .in_arith  (in_arith),
    .rot_in    (rot_in),
    .rot_cnt   (rot_cnt),
    .rot_out   (rot_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFT_ISSUE_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_ops    (stat_ops),
    .stat_stalls (stat_stalls)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational left rotator the stage is meant to drive
  logic [31:0] rot_dd;
  always_comb begin
    rot_dd  = {rot_in, rot_in} << rot_cnt;
    rot_out = rot_dd[31:16];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: bitwise rotation by index arithmetic, shifts by operators
  function automatic logic [15:0] model(input logic [1:0] op, input logic arith,
                                        input logic [15:0] d, input logic [3:0] k);
    logic [15:0] r;
    int unsigned kk;
    kk = k;
    r  = '0;
    case (op)
      2'b00: for (int unsigned i = 0; i < 16; i++) r[(i + kk) % 16] = d[i];
      2'b01: r = d << kk;
      2'b10: for (int unsigned i = 0; i < 16; i++) r[i] = d[(i + kk) % 16];
      default: r = arith ? 16'($signed(d) >>> kk) : (d >> kk);
    endcase
    return r;
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic        arith;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [15:0] exp_out;
    logic [3:0]  exp_rc;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic        arith;
    logic [15:0] data;
    logic [3:0]  cnt;
  } req_t;

  vec_t vt[10];
  req_t reqs[$];

  task automatic drive_req(input req_t r);
    in_valid = 1'b1;
    in_op    = r.op;
    in_arith = r.arith;
    in_data  = r.data;
    in_cnt   = r.cnt;
  endtask

  // Streams reqs through the DUT; outputs are scored against the model in order
  task automatic run_stream(input bit rnd, input int stall_len, input int budget,
                            output bit saw_block);
    logic [15:0] exp_q[$];
    logic [15:0] held;
    int idx, got, cyc, stall_left;
    bit stalled_prev, stall_done;
    idx = 0; got = 0; cyc = 0; stall_left = 0;
    stalled_prev = 0; stall_done = 0; saw_block = 0; held = '0;
    while (got < reqs.size() && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (stalled_prev) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_data_held", 32'(out_data), 32'(held));
      end
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        if (!stall_done && out_valid && stall_len > 0) begin
          stall_left = stall_len;
          stall_done = 1;
        end
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      if (idx < reqs.size()) begin
        drive_req(reqs[idx]);
        if (rnd) in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      stalled_prev = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream_extra_out: got 0x%0h expected no output", out_data);
        end else begin
          check("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(reqs[idx].op, reqs[idx].arith, reqs[idx].data, reqs[idx].cnt));
        idx++;
      end
      if (in_valid && !in_ready) saw_block = 1;
    end
    check("stream_count", 32'(got), 32'(reqs.size()));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("stream_drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit blk;
    vt[0] = '{2'b00, 1'b0, 16'h8001, 4'd1,  16'h0003, 4'd1};
    vt[1] = '{2'b01, 1'b0, 16'h8001, 4'd4,  16'h0010, 4'd4};
    vt[2] = '{2'b11, 1'b0, 16'h8001, 4'd4,  16'h0800, 4'd12};
    vt[3] = '{2'b11, 1'b1, 16'h8001, 4'd4,  16'hF800, 4'd12};
    vt[4] = '{2'b10, 1'b0, 16'h0001, 4'd1,  16'h8000, 4'd15};
    vt[5] = '{2'b10, 1'b0, 16'h1234, 4'd0,  16'h1234, 4'd0};
    vt[6] = '{2'b11, 1'b1, 16'h8000, 4'd15, 16'hFFFF, 4'd1};
    vt[7] = '{2'b11, 1'b0, 16'h8000, 4'd15, 16'h0001, 4'd1};
    vt[8] = '{2'b01, 1'b0, 16'hFFFF, 4'd0,  16'hFFFF, 4'd0};
    vt[9] = '{2'b11, 1'b1, 16'h7FF0, 4'd4,  16'h07FF, 4'd12};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cnt = '0; in_op = '0;
    in_arith = 1'b0; out_ready = 1'b0;
`ifdef SHIFT_ISSUE_STATS_EN
    stat_clr = 1'b0;
`endif
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rot_in", 32'(rot_in), 32'd0);
`ifdef SHIFT_ISSUE_STATS_EN
    check("rst_stat_ops", 32'(stat_ops), 32'd0);
    check("rst_stat_stalls", 32'(stat_stalls), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive_req('{vt[i].op, vt[i].arith, vt[i].data, vt[i].cnt});
      out_ready = 1'b1;
      #1 check("vec_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("vec_rot_cnt", 32'(rot_cnt), 32'(vt[i].exp_rc));
      check("vec_rot_in", 32'(rot_in), 32'(vt[i].data));
      check("vec_valid_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1;
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_out_data", 32'(out_data), 32'(vt[i].exp_out));
    end
    @(negedge clk);

`ifdef SHIFT_ISSUE_STATS_EN
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("clr_stat_ops", 32'(stat_ops), 32'd0);
    check("clr_stat_stalls", 32'(stat_stalls), 32'd0);
`endif

    reqs.delete();
    for (int i = 0; i < 4; i++) reqs.push_back('{2'b00, 1'b0, 16'h0001, 4'(i)});
    run_stream(1'b0, 3, 200, blk);
    check("bp_in_ready_dropped", 32'(blk), 32'd1);
`ifdef SHIFT_ISSUE_STATS_EN
    check("bp_stat_ops", 32'(stat_ops), 32'd4);
    check("bp_stat_stalls", 32'(stat_stalls), 32'd3);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("clr2_stat_ops", 32'(stat_ops), 32'd0);
    check("clr2_stat_stalls", 32'(stat_stalls), 32'd0);
`endif

    reqs.delete();
    for (int i = 0; i < 200; i++)
      reqs.push_back('{2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       16'($urandom), 4'($urandom_range(0, 15))});
    run_stream(1'b1, 0, 5000, blk);

    @(negedge clk);
    out_ready = 1'b0;
    drive_req('{2'b00, 1'b0, 16'h0001, 4'd1});
    @(negedge clk);
    drive_req('{2'b00, 1'b0, 16'h0001, 4'd2});
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive_req('{2'b01, 1'b0, 16'h0003, 4'd2});
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("post_rst_valid_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd1);
    check("post_rst_out_data", 32'(out_data), 32'h000C);
    @(negedge clk);
    #1 check("post_rst_no_dup", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
